jesd204b_tx_data_path: RTL and testbench

- Transmit-side JESD204B link-layer data path. Pairs with the receiver data path across the serial lane.
- Generates CGS (/K28.5/) while SYNC~ is asserted and, on the next LMFC boundary after release, a 4-multiframe ILAS carrying the link configuration.
- Then streams user sample words to the GTX transmitter with a valid/ready handshake.
- Sits between the sample framer and the GTX TX parallel interface (gtx_data_o / gtx_charisk_o).

---
 rtl/jesd204b_tx_data_path_if.sv | 11 +
 rtl/jesd204b_tx_data_path.sv | 208 ++++++++++++++++++++
 tb/tb_jesd204b_tx_data_path.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jesd204b_tx_data_path_if.sv
// User-side sample stream into the JESD204B TX data path: word, valid, ready.
interface jesd204b_tx_data_path_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] data_i;
  logic                  data_valid_i;
  logic                  data_ready_o;

  modport master (output data_i, output data_valid_i, input data_ready_o);
  modport slave  (input data_i, input data_valid_i, output data_ready_o);
endinterface

// File: rtl/jesd204b_tx_data_path.sv
// JESD204B TX link layer: CGS while SYNC~ low, LMFC-aligned ILAS, then user data.
// Optional payload scrambler (1+x^14+x^15) enabled by defining JESD_TX_SCRAMBLE_EN.
module jesd204b_tx_data_path #(
  parameter int unsigned PARALLEL_OCTETS  = 4,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned OCTETS_PER_MF    = 128,
  parameter int unsigned ILAS_MULTIFRAMES = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       sync_ni,
  input  logic [111:0]               cfg_i,
  jesd204b_tx_data_path_if.slave     s_if,
  output logic [DATA_WIDTH-1:0]      gtx_data_o,
  output logic [PARALLEL_OCTETS-1:0] gtx_charisk_o,
  output logic                       lmfc_o,
  output logic [1:0]                 state_o,
  output logic                       underflow_o
);

  localparam int unsigned WPM   = OCTETS_PER_MF / PARALLEL_OCTETS;
  localparam int unsigned CNT_W = (WPM > 1) ? $clog2(WPM) : 1;
  localparam int unsigned MF_W  = $clog2(ILAS_MULTIFRAMES);
  localparam int unsigned WK_W  = PARALLEL_OCTETS + DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0]      K_WORD = {PARALLEL_OCTETS{8'hBC}};
  localparam logic [PARALLEL_OCTETS-1:0] K_ALL  = {PARALLEL_OCTETS{1'b1}};

  typedef enum logic [1:0] {
    ST_CGS  = 2'd0,
    ST_ILAS = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // ILAS word for word slot widx; returns {charisk, data}
  function automatic logic [WK_W-1:0] ilas_word(input logic mf_is_1,
                                                input logic [CNT_W-1:0] widx,
                                                input logic [111:0] cfg);
    logic [DATA_WIDTH-1:0]      d;
    logic [PARALLEL_OCTETS-1:0] k;
    int unsigned                j;
    d = '0;
    k = '0;
    for (int unsigned p = 0; p < PARALLEL_OCTETS; p++) begin
      j = 32'(widx) * PARALLEL_OCTETS + p;
      d[8*p +: 8] = 8'(j);
      if (j == 0) begin
        d[8*p +: 8] = 8'h1C;
        k[p]        = 1'b1;
      end else if (j == OCTETS_PER_MF - 1) begin
        d[8*p +: 8] = 8'h7C;
        k[p]        = 1'b1;
      end else if (mf_is_1 && j == 1) begin
        d[8*p +: 8] = 8'h9C;
        k[p]        = 1'b1;
      end else if (mf_is_1 && j >= 2 && j <= 15) begin
        d[8*p +: 8] = cfg[8*(j-2) +: 8];
      end
    end
    return {k, d};
  endfunction

`ifdef JESD_TX_SCRAMBLE_EN
  // Serial scrambler over a word, octet 0 first, MSB first; returns {state, data}
  function automatic logic [15+DATA_WIDTH-1:0] scramble(input logic [14:0] s_in,
                                                        input logic [DATA_WIDTH-1:0] d);
    logic [14:0]           s;
    logic [DATA_WIDTH-1:0] o;
    logic                  b;
    s = s_in;
    o = '0;
    for (int p = 0; p < int'(PARALLEL_OCTETS); p++) begin
      for (int i = 7; i >= 0; i--) begin
        b          = d[8*p+i] ^ s[13] ^ s[14];
        o[8*p+i]   = b;
        s          = {s[13:0], b};
      end
    end
    return {s, o};
  endfunction
`endif

  state_t                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [MF_W-1:0]            r_mf;
  logic [111:0]               r_cfg;
  logic [DATA_WIDTH-1:0]      r_data;
  logic [PARALLEL_OCTETS-1:0] r_k;
  logic                       r_lmfc;
  logic                       r_ready;
  logic                       r_uf;
`ifdef JESD_TX_SCRAMBLE_EN
  logic [14:0]                r_scr;
  logic [14:0]                w_scr_nxt;
`endif

  logic [CNT_W-1:0]           w_cnt_nxt;
  logic [MF_W-1:0]            w_mf_nxt;
  logic                       w_ilas_last;
  logic [DATA_WIDTH-1:0]      w_ilas_data;
  logic [PARALLEL_OCTETS-1:0] w_ilas_k;
  logic                       w_accept;
  logic [DATA_WIDTH-1:0]      w_payload;
  logic [DATA_WIDTH-1:0]      w_tx;

  // Next LMFC position and ILAS word; content always targets the next slot
  always_comb begin
    w_cnt_nxt   = (r_cnt == CNT_W'(WPM - 1)) ? '0 : r_cnt + CNT_W'(1);
    w_mf_nxt    = (w_cnt_nxt == '0) ? r_mf + MF_W'(1) : r_mf;
    w_ilas_last = (w_mf_nxt == MF_W'(ILAS_MULTIFRAMES - 1)) &&
                  (w_cnt_nxt == CNT_W'(WPM - 1));
    {w_ilas_k, w_ilas_data} = ilas_word((r_state == ST_ILAS) && (w_mf_nxt == MF_W'(1)),
                                        w_cnt_nxt, r_cfg);
    w_accept  = r_ready & s_if.data_valid_i;
    w_payload = w_accept ? s_if.data_i : '0;
`ifdef JESD_TX_SCRAMBLE_EN
    {w_scr_nxt, w_tx} = scramble(r_scr, w_payload);
`else
    w_tx = w_payload;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_CGS;
      r_cnt   <= '0;
      r_mf    <= '0;
      r_cfg   <= '0;
      r_data  <= K_WORD;
      r_k     <= K_ALL;
      r_lmfc  <= 1'b0;
      r_ready <= 1'b0;
      r_uf    <= 1'b0;
`ifdef JESD_TX_SCRAMBLE_EN
      r_scr   <= 15'h7FFF;
`endif
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_lmfc <= (w_cnt_nxt == '0);
      case (r_state)
        ST_CGS: begin
          r_ready <= 1'b0;
          if (sync_ni && w_cnt_nxt == '0) begin
            r_state <= ST_ILAS;
            r_mf    <= '0;
            r_cfg   <= cfg_i;
            r_data  <= w_ilas_data;
            r_k     <= w_ilas_k;
          end else begin
            r_data <= K_WORD;
            r_k    <= K_ALL;
          end
        end
        ST_ILAS: begin
          if (!sync_ni) begin
            r_state <= ST_CGS;
            r_data  <= K_WORD;
            r_k     <= K_ALL;
            r_ready <= 1'b0;
            r_uf    <= 1'b0;
          end else begin
            r_mf   <= w_mf_nxt;
            r_data <= w_ilas_data;
            r_k    <= w_ilas_k;
            // Ready is raised alongside the final /A/ so data starts on the LMFC
            if (w_ilas_last) begin
              r_state <= ST_DATA;
              r_ready <= 1'b1;
`ifdef JESD_TX_SCRAMBLE_EN
              r_scr   <= 15'h7FFF;
`endif
            end
          end
        end
        ST_DATA: begin
          if (!sync_ni) begin
            r_state <= ST_CGS;
            r_data  <= K_WORD;
            r_k     <= K_ALL;
            r_ready <= 1'b0;
            r_uf    <= 1'b0;
          end else begin
            r_data <= w_tx;
            r_k    <= '0;
            if (!w_accept) r_uf <= 1'b1;
`ifdef JESD_TX_SCRAMBLE_EN
            r_scr  <= w_scr_nxt;
`endif
          end
        end
        default: begin
          r_state <= ST_CGS;
          r_data  <= K_WORD;
          r_k     <= K_ALL;
          r_ready <= 1'b0;
          r_uf    <= 1'b0;
        end
      endcase
    end
  end

  assign gtx_data_o        = r_data;
  assign gtx_charisk_o     = r_k;
  assign lmfc_o            = r_lmfc;
  assign state_o           = r_state;
  assign underflow_o       = r_uf;
  assign s_if.data_ready_o = r_ready;

endmodule

// File: tb/tb_jesd204b_tx_data_path.sv
// Bench for jesd204b_tx_data_path: reference link model checked every cycle plus literal spot checks.
module tb_jesd204b_tx_data_path;

  localparam int WPM        = 32;
  localparam int ILAS_WORDS = 128;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b1;
  logic         sync_ni;
  logic [111:0] cfg;
  logic [31:0]  gtx_data;
  logic [3:0]   gtx_k;
  logic         lmfc;
  logic [1:0]   state;
  logic         uf;

  int n_total = 0;
  int n_bad   = 0;
  logic done = 1'b0;

  always #5 clk = ~clk;

  jesd204b_tx_data_path_if #(.DATA_WIDTH(32)) u_if ();

  jesd204b_tx_data_path #(
    .PARALLEL_OCTETS(4), .DATA_WIDTH(32), .OCTETS_PER_MF(128), .ILAS_MULTIFRAMES(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .sync_ni(sync_ni), .cfg_i(cfg), .s_if(u_if),
    .gtx_data_o(gtx_data), .gtx_charisk_o(gtx_k), .lmfc_o(lmfc),
    .state_o(state), .underflow_o(uf)
  );

  // ---------------- reference model ----------------
  int           m_cnt;
  int           m_mode;
  int           m_n;
  logic [111:0] m_cfg;
  logic [31:0]  e_data;
  logic [3:0]   e_k;
  logic         e_lmfc, e_ready, e_uf;
  logic [1:0]   e_state;
`ifdef JESD_TX_SCRAMBLE_EN
  logic         hist[$];
  logic         sbit;
`endif
  logic [31:0]  w;
  logic [8:0]   ok;

  // ILAS octet p of the n-th ILAS word (0..127): {k, octet}
  function automatic logic [8:0] ilas_oct(input int n, input int p, input logic [111:0] c);
    int mf = n / WPM;
    int j  = (n % WPM) * 4 + p;
    if (j == 0)                        return {1'b1, 8'h1C};
    if (j == 4 * WPM - 1)              return {1'b1, 8'h7C};
    if (mf == 1 && j == 1)             return {1'b1, 8'h9C};
    if (mf == 1 && j >= 2 && j <= 15)  return {1'b0, c[8*(j-2) +: 8]};
    return {1'b0, 8'(j)};
  endfunction

  task automatic model_ilas(input int n);
    for (int p = 0; p < 4; p++) begin
      ok = ilas_oct(n, p, m_cfg);
      e_data[8*p +: 8] = ok[7:0];
      e_k[p]           = ok[8];
    end
  endtask

  task automatic model_cgs();
    m_mode = 0;
    e_data = 32'hBCBCBCBC;
    e_k    = 4'hF;
    e_uf   = 1'b0;
  endtask

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_cnt = 0; m_mode = 0; m_n = 0; m_cfg = '0;
      e_data = 32'hBCBCBCBC; e_k = 4'hF;
      e_lmfc = 1'b0; e_ready = 1'b0; e_uf = 1'b0; e_state = 2'd0;
    end else begin
      m_cnt  = (m_cnt + 1) % WPM;
      e_lmfc = (m_cnt == 0);
      case (m_mode)
        0: begin
          if (sync_ni && m_cnt == 0) begin
            m_mode = 1; m_n = 0; m_cfg = cfg;
            model_ilas(0);
          end else model_cgs();
        end
        1: begin
          if (!sync_ni) model_cgs();
          else begin
            m_n++;
            model_ilas(m_n);
            if (m_n == ILAS_WORDS - 1) begin
              m_mode = 2;
`ifdef JESD_TX_SCRAMBLE_EN
              hist.delete();
              for (int i = 0; i < 15; i++) hist.push_back(1'b1);
`endif
            end
          end
        end
        default: begin
          if (!sync_ni) model_cgs();
          else begin
            if (e_ready && u_if.data_valid_i) w = u_if.data_i;
            else begin w = '0; e_uf = 1'b1; end
`ifdef JESD_TX_SCRAMBLE_EN
            for (int p = 0; p < 4; p++)
              for (int b = 7; b >= 0; b--) begin
                sbit = w[8*p+b] ^ hist[hist.size()-14] ^ hist[hist.size()-15];
                w[8*p+b] = sbit;
                hist.push_back(sbit);
                void'(hist.pop_front());
              end
`endif
            e_data = w;
            e_k    = 4'h0;
          end
        end
      endcase
      e_ready = (m_mode == 2);
      e_state = 2'(m_mode);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!done)
      check("cycle {data,k,state,ready,lmfc,uf}",
            {23'd0, gtx_data, gtx_k, state, u_if.data_ready_o, lmfc, uf},
            {23'd0, e_data, e_k, e_state, e_ready, e_lmfc, e_uf});
  end

  task automatic wait_cnt(input int c, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (m_cnt != c && n < 100);
    if (m_cnt != c) begin
      n_total++; n_bad++;
      $display("FAIL %s: timeout waiting for counter %0d", nm, c);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int lim, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (e_state != s && n < lim);
    if (e_state != s) begin
      n_total++; n_bad++;
      $display("FAIL %s: timeout waiting for state %0d", nm, s);
    end
  endtask

  task automatic check_reset(input string nm);
    check({nm, " data"}, 64'(gtx_data), 64'hBCBCBCBC);
    check({nm, " k/state/ready/lmfc/uf"},
          64'({gtx_k, state, u_if.data_ready_o, lmfc, uf}), 64'({4'hF, 2'd0, 3'b000}));
  endtask

  task automatic stream(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      u_if.data_valid_i = ($urandom_range(0, 3) != 0);
`ifdef JESD_TX_SCRAMBLE_EN
      u_if.data_i = '0;
`else
      u_if.data_i = $urandom;
`endif
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sync_ni = 1'b0;
    u_if.data_valid_i = 1'b0;
    u_if.data_i = '0;
    for (int i = 0; i < 14; i++) cfg[8*i +: 8] = 8'(i);
    #1 rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset("reset");
    #1 rst_ni = 1'b1;

    // CGS forever while SYNC~ low
    repeat (100) @(negedge clk);
    check("cgs after 100", 64'({gtx_data, gtx_k, state}), 64'({32'hBCBCBCBC, 4'hF, 2'd0}));

    // release mid-multiframe; ILAS must wait for the boundary
    wait_cnt(10, "release point");
    sync_ni = 1'b1;
    @(negedge clk);
    check("cgs holds mid-mf", 64'({gtx_data, gtx_k, state}), 64'({32'hBCBCBCBC, 4'hF, 2'd0}));
    wait_cnt(0, "ilas mf0");
    check("ilas mf0 w0", 64'({gtx_data, gtx_k, state, lmfc}), 64'({32'h0302011C, 4'b0001, 2'd1, 1'b1}));
    wait_cnt(31, "ilas mf0 end");
    check("ilas mf0 w31", 64'({gtx_data, gtx_k}), 64'({32'h7C7E7D7C, 4'b1000}));
    wait_cnt(0, "ilas mf1");
    check("ilas mf1 w0", 64'({gtx_data, gtx_k}), 64'({32'h01009C1C, 4'b0011}));
    @(negedge clk);
    check("ilas mf1 w1", 64'({gtx_data, gtx_k}), 64'({32'h05040302, 4'b0000}));

    // DATA entry with the last /A/ on the line
    wait_state(2'd2, 200, "data entry");
    check("data entry", 64'({gtx_data, gtx_k, state, u_if.data_ready_o}),
          64'({32'h7C7E7D7C, 4'b1000, 2'd2, 1'b1}));
    u_if.data_i = 32'hDEADBEEF;
    u_if.data_valid_i = 1'b1;
    @(negedge clk);
`ifndef JESD_TX_SCRAMBLE_EN
    check("first data word", 64'({gtx_data, gtx_k, uf}), 64'({32'hDEADBEEF, 4'h0, 1'b0}));
`endif
    u_if.data_valid_i = 1'b0;
    @(negedge clk);
`ifndef JESD_TX_SCRAMBLE_EN
    check("underflow word", 64'({gtx_data, gtx_k, uf}), 64'({32'h00000000, 4'h0, 1'b1}));
`else
    check("underflow flag", 64'(uf), 64'd1);
`endif
    stream(40);

    // SYNC~ drop mid-DATA with a word in flight
    sync_ni = 1'b0;
    u_if.data_valid_i = 1'b1;
    u_if.data_i = 32'h12345678;
    @(negedge clk);
    check("drop in data", 64'({gtx_data, gtx_k, state, u_if.data_ready_o, uf}),
          64'({32'hBCBCBCBC, 4'hF, 2'd0, 1'b0, 1'b0}));
    u_if.data_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    sync_ni = 1'b1;
    wait_state(2'd1, 64, "ilas restart");
    check("ilas restart on lmfc", 64'({gtx_data, gtx_k, lmfc}), 64'({32'h0302011C, 4'b0001, 1'b1}));

    // SYNC~ drop mid-ILAS
    repeat (40) @(negedge clk);
    sync_ni = 1'b0;
    @(negedge clk);
    check("drop in ilas", 64'({gtx_data, gtx_k, state, u_if.data_ready_o}),
          64'({32'hBCBCBCBC, 4'hF, 2'd0, 1'b0}));
    repeat (3) @(negedge clk);
    sync_ni = 1'b1;
    wait_state(2'd2, 300, "data re-entry");
    stream(20);

    // async reset mid-DATA
    #2 rst_ni = 1'b0;
    #1 check_reset("reset mid-data");
    @(negedge clk);
    #2 rst_ni = 1'b1;
    repeat (40) @(negedge clk);

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
